// File: rtl/cache_lru_pkg.sv
// Shared defaults and FSM state type for the cache LRU update scheduler.
package cache_lru_pkg;

    localparam int SET_W_DEF = 11;
    localparam int WAY_W_DEF = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        MISS_UPD = 1'b1
    } sched_state_t;

endpackage

// File: rtl/cache_lru_req_arb.sv
// Two-requester arbiter for the LRU scheduler.
// CACHE_LRU_SCHED_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module cache_lru_req_arb (
`ifdef CACHE_LRU_SCHED_RR_EN
    input  logic       main_clk,
    input  logic       rst,
`endif
    input  logic [1:0] req_valid,
    input  logic       enable,
    output logic [1:0] grant
);

`ifdef CACHE_LRU_SCHED_RR_EN
    logic last_port;

    // On contention the requester that was not granted last time wins.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_port ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            last_port <= 1'b0;
        end else if (grant != 2'b00) begin
            last_port <= grant[1];
        end
    end
`else
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req_valid[0]) begin
                grant = 2'b01;
            end else if (req_valid[1]) begin
                grant = 2'b10;
            end
        end
    end
`endif

endmodule

// File: rtl/cache_lru_scheduler.sv
// Schedules hit/miss LRU updates from two requesters onto one LRU store port.
// Arbitration policy is chosen by CACHE_LRU_SCHED_RR_EN (round-robin when defined).
module cache_lru_scheduler
    import cache_lru_pkg::*;
#(
    parameter int SET_W = SET_W_DEF,
    parameter int WAY_W = WAY_W_DEF
) (
    input  logic             main_clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [SET_W-1:0] req_set0,
    input  logic [SET_W-1:0] req_set1,
    input  logic [1:0]       req_hit,
    input  logic [WAY_W-1:0] req_way0,
    input  logic [WAY_W-1:0] req_way1,
    output logic             rsp_valid,
    output logic             rsp_port,
    output logic [WAY_W-1:0] rsp_way,
    output logic [SET_W-1:0] lru_addr,
    output logic [WAY_W-1:0] lru_used_index,
    output logic             lru_enable_write,
    input  logic [WAY_W-1:0] lru_least_used_index
);

    sched_state_t     state;
    logic [SET_W-1:0] miss_set;
    logic             miss_port;
    logic [1:0]       grant;
    logic             accept;
    logic             sel_port;
    logic [SET_W-1:0] sel_set;
    logic             sel_hit;
    logic [WAY_W-1:0] sel_way;

    cache_lru_req_arb u_arb (
`ifdef CACHE_LRU_SCHED_RR_EN
        .main_clk  (main_clk),
        .rst       (rst),
`endif
        .req_valid (req_valid),
        .enable    (state == IDLE),
        .grant     (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    // Grant is one-hot, so its upper bit names the selected requester.
    always_comb begin
        sel_port = grant[1];
        sel_set  = sel_port ? req_set1 : req_set0;
        sel_way  = sel_port ? req_way1 : req_way0;
        sel_hit  = req_hit[sel_port];
    end

    // A miss reads the victim in the accept cycle and writes it back the next cycle.
    always_comb begin
        lru_addr         = '0;
        lru_used_index   = '0;
        lru_enable_write = 1'b0;
        if (state == MISS_UPD) begin
            lru_addr         = miss_set;
            lru_used_index   = lru_least_used_index;
            lru_enable_write = 1'b1;
        end else if (accept) begin
            lru_addr = sel_set;
            if (sel_hit) begin
                lru_used_index   = sel_way;
                lru_enable_write = 1'b1;
            end
        end
    end

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_port  <= 1'b0;
            rsp_way   <= '0;
            miss_set  <= '0;
            miss_port <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (sel_hit) begin
                            rsp_valid <= 1'b1;
                            rsp_port  <= sel_port;
                            rsp_way   <= sel_way;
                        end else begin
                            miss_set  <= sel_set;
                            miss_port <= sel_port;
                            state     <= MISS_UPD;
                        end
                    end
                end
                MISS_UPD: begin
                    rsp_valid <= 1'b1;
                    rsp_port  <= miss_port;
                    rsp_way   <= lru_least_used_index;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_lru_scheduler.sv
// Directed bench for cache_lru_scheduler with a true-LRU store model.
// Expected grant order follows CACHE_LRU_SCHED_RR_EN when it is defined for the build.
module tb_cache_lru_scheduler;

    localparam int SET_W = 11;
    localparam int WAY_W = 2;

    logic             main_clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [SET_W-1:0] req_set0;
    logic [SET_W-1:0] req_set1;
    logic [1:0]       req_hit;
    logic [WAY_W-1:0] req_way0;
    logic [WAY_W-1:0] req_way1;
    logic             rsp_valid;
    logic             rsp_port;
    logic [WAY_W-1:0] rsp_way;
    logic [SET_W-1:0] lru_addr;
    logic [WAY_W-1:0] lru_used_index;
    logic             lru_enable_write;
    logic [WAY_W-1:0] lru_least_used_index;

    int checks;
    int failures;

    cache_lru_scheduler #(.SET_W(SET_W), .WAY_W(WAY_W)) dut (
        .main_clk             (main_clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_set0             (req_set0),
        .req_set1             (req_set1),
        .req_hit              (req_hit),
        .req_way0             (req_way0),
        .req_way1             (req_way1),
        .rsp_valid            (rsp_valid),
        .rsp_port             (rsp_port),
        .rsp_way              (rsp_way),
        .lru_addr             (lru_addr),
        .lru_used_index       (lru_used_index),
        .lru_enable_write     (lru_enable_write),
        .lru_least_used_index (lru_least_used_index)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    // LRU store: ages per way (3 = least recent), write-through forwarding to the read.
    logic [1:0] age_mem [0:2047][0:3];

    always @(posedge main_clk) begin
        if (rst) begin
            for (int s = 0; s < 2048; s++) begin
                for (int w = 0; w < 4; w++) begin
                    age_mem[s][w] <= 2'(w);
                end
            end
            lru_least_used_index <= '0;
        end else begin : model
            automatic logic [1:0] a [4];
            automatic logic [1:0] ua;
            automatic logic [1:0] v;
            v = '0;
            for (int w = 0; w < 4; w++) begin
                a[w] = age_mem[lru_addr][w];
            end
            if (lru_enable_write) begin
                ua = a[lru_used_index];
                for (int w = 0; w < 4; w++) begin
                    if (a[w] < ua) begin
                        a[w] = a[w] + 2'd1;
                    end
                end
                a[lru_used_index] = 2'd0;
                for (int w = 0; w < 4; w++) begin
                    age_mem[lru_addr][w] <= a[w];
                end
            end
            for (int w = 0; w < 4; w++) begin
                if (a[w] == 2'd3) begin
                    v = 2'(w);
                end
            end
            lru_least_used_index <= v;
        end
    end

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] hit,
                                 input logic [SET_W-1:0] s0, input logic [SET_W-1:0] s1,
                                 input logic [WAY_W-1:0] w0, input logic [WAY_W-1:0] w1);
        req_valid = valid;
        req_hit   = hit;
        req_set0  = s0;
        req_set1  = s1;
        req_way0  = w0;
        req_way1  = w1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    int exp_grant [8];
    int cnt0;
    int cnt1;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);

`ifdef CACHE_LRU_SCHED_RR_EN
        exp_grant = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_grant = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif

        // Reset state
        repeat (2) @(negedge main_clk);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_port", 32'(rsp_port), 32'h0);
        checkOutput("rst_rsp_way", 32'(rsp_way), 32'h0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_we", 32'(lru_enable_write), 32'h0);
        rst = 1'b0;

        // Single hit, port 0, set 0x155, way 2
        @(negedge main_clk);
        applyStimulus(2'b01, 2'b01, 11'h155, '0, 2'd2, '0);
        #1;
        checkOutput("hit_ready", 32'(req_ready), 32'h1);
        checkOutput("hit_we", 32'(lru_enable_write), 32'h1);
        checkOutput("hit_addr", 32'(lru_addr), 32'h155);
        checkOutput("hit_used", 32'(lru_used_index), 32'h2);
        @(negedge main_clk);
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
        checkOutput("hit_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("hit_rsp_port", 32'(rsp_port), 32'h0);
        checkOutput("hit_rsp_way", 32'(rsp_way), 32'h2);
        #1;
        checkOutput("idle_addr", 32'(lru_addr), 32'h0);
        checkOutput("idle_we", 32'(lru_enable_write), 32'h0);

        // Miss, port 1, set 0x7FF, victim 3
        @(negedge main_clk);
        checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        applyStimulus(2'b10, 2'b00, '0, 11'h7FF, '0, '0);
        #1;
        checkOutput("miss_ready", 32'(req_ready), 32'h2);
        checkOutput("miss_we_t0", 32'(lru_enable_write), 32'h0);
        checkOutput("miss_addr_t0", 32'(lru_addr), 32'h7FF);
        @(negedge main_clk);
        applyStimulus(2'b11, 2'b11, 11'h001, 11'h002, 2'd0, 2'd0);
        checkOutput("miss_rsp_valid_t1", 32'(rsp_valid), 32'h0);
        #1;
        checkOutput("miss_ready_t1", 32'(req_ready), 32'h0);
        checkOutput("miss_we_t1", 32'(lru_enable_write), 32'h1);
        checkOutput("miss_addr_t1", 32'(lru_addr), 32'h7FF);
        checkOutput("miss_used_t1", 32'(lru_used_index), 32'h3);
        @(negedge main_clk);
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
        checkOutput("miss_rsp_valid_t2", 32'(rsp_valid), 32'h1);
        checkOutput("miss_rsp_port_t2", 32'(rsp_port), 32'h1);
        checkOutput("miss_rsp_way_t2", 32'(rsp_way), 32'h3);
        @(negedge main_clk);
        checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("hold_rsp_port", 32'(rsp_port), 32'h1);
        checkOutput("hold_rsp_way", 32'(rsp_way), 32'h3);

        // Both ports valid, four hits each
        cnt0 = 4;
        cnt1 = 4;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(negedge main_clk);
                checkOutput($sformatf("arb_rsp_valid_%0d", i - 1), 32'(rsp_valid), 32'h1);
                checkOutput($sformatf("arb_rsp_port_%0d", i - 1), 32'(rsp_port),
                            32'(exp_grant[i - 1]));
            end
            applyStimulus({cnt1 > 0, cnt0 > 0}, 2'b11, 11'h020, 11'h030, 2'd1, 2'd2);
            #1;
            checkOutput($sformatf("arb_ready_%0d", i), 32'(req_ready),
                        (exp_grant[i] == 1) ? 32'h2 : 32'h1);
            checkOutput($sformatf("arb_used_%0d", i), 32'(lru_used_index),
                        (exp_grant[i] == 1) ? 32'h2 : 32'h1);
            if (exp_grant[i] == 1) cnt1--;
            else cnt0--;
        end
        @(negedge main_clk);
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
        checkOutput("arb_rsp_port_7", 32'(rsp_port), 32'(exp_grant[7]));

        // Same-set hits on ways 0..3, then a miss picks way 0
        for (int w = 0; w < 4; w++) begin
            @(negedge main_clk);
            applyStimulus(2'b01, 2'b01, 11'h010, '0, 2'(w), '0);
            #1;
            checkOutput($sformatf("seq_we_%0d", w), 32'(lru_enable_write), 32'h1);
        end
        @(negedge main_clk);
        checkOutput("seq_rsp_way_3", 32'(rsp_way), 32'h3);
        applyStimulus(2'b01, 2'b00, 11'h010, '0, '0, '0);
        #1;
        checkOutput("seq_miss_we_t0", 32'(lru_enable_write), 32'h0);
        @(negedge main_clk);
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
        #1;
        checkOutput("seq_miss_used_t1", 32'(lru_used_index), 32'h0);
        @(negedge main_clk);
        checkOutput("seq_miss_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("seq_miss_rsp_way", 32'(rsp_way), 32'h0);

        // Reset during MISS_UPD abandons the miss
        @(negedge main_clk);
        applyStimulus(2'b01, 2'b00, 11'h0AB, '0, '0, '0);
        @(negedge main_clk);
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
        rst = 1'b1;
        #1;
        checkOutput("abort_we", 32'(lru_enable_write), 32'h0);
        checkOutput("abort_addr", 32'(lru_addr), 32'h0);
        @(negedge main_clk);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("abort_rsp_way", 32'(rsp_way), 32'h0);
        rst = 1'b0;
        applyStimulus(2'b10, 2'b10, '0, 11'h044, '0, 2'd1);
        #1;
        checkOutput("post_rst_ready", 32'(req_ready), 32'h2);
        checkOutput("post_rst_we", 32'(lru_enable_write), 32'h1);
        @(negedge main_clk);
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
        checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("post_rst_rsp_port", 32'(rsp_port), 32'h1);
        checkOutput("post_rst_rsp_way", 32'(rsp_way), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_lru_scheduler.md
CACHE_LRU_SCHEDULER -- requirements
Module: cache_lru_scheduler

Interface
REQ-001 SHALL have parameter SET_W, default 11: LRU set-index width.
REQ-002 SHALL have parameter WAY_W, default 2: way-index width (4 ways).
REQ-003 SHALL have port main_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset. One clock; reset is asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 2: per-requester request valid; bit i is requester i.
REQ-006 SHALL have port req_ready, output, 2: per-requester accept; one-hot or zero.
REQ-007 SHALL have ports req_set0 and req_set1, input, SET_W each: set index per requester.
REQ-008 SHALL have port req_hit, input, 2: 1 = tag hit; 0 = miss, victim needed.
REQ-009 SHALL have ports req_way0 and req_way1, input, WAY_W each: hit way; ignored on miss.
REQ-010 SHALL have port rsp_valid, output, 1: one-cycle response pulse.
REQ-011 SHALL have port rsp_port, output, 1: requester the response belongs to.
REQ-012 SHALL have port rsp_way, output, WAY_W: hit way, or chosen victim on miss.
REQ-013 SHALL have port lru_addr, output, SET_W: set index driven to the LRU store.
REQ-014 SHALL have port lru_used_index, output, WAY_W: way marked most-recent on write.
REQ-015 SHALL have port lru_enable_write, output, 1: LRU update strobe.
REQ-016 SHALL have port lru_least_used_index, input, WAY_W: LRU victim, valid the cycle after lru_addr is presented; reflects pre-update state.

Function
REQ-017 SHALL use FSM states IDLE and MISS_UPD.
REQ-018 SHALL make req_ready combinational: nonzero only in IDLE, equal to the arbiter grant over req_valid.
REQ-019 SHALL accept a request in a cycle where req_valid[i] and req_ready[i] are both 1; requesters hold valid/set/hit/way until accepted.
REQ-020 Hit accepted at cycle T: SHALL drive lru_addr=set, lru_used_index=way, lru_enable_write=1 in T and stay IDLE; rsp_valid=1, rsp_way=way at T+1.
REQ-021 Miss accepted at cycle T: SHALL drive lru_addr=set, lru_enable_write=0 in T and enter MISS_UPD.
REQ-022 In MISS_UPD (T+1): SHALL capture lru_least_used_index as victim, drive lru_addr=same set, lru_used_index=victim, lru_enable_write=1, then return to IDLE; rsp_valid=1, rsp_way=victim at T+2.
REQ-023 Throughput SHALL be one hit per cycle back-to-back; a miss occupies two cycles with req_ready=0 in MISS_UPD.
REQ-024 Same-set back-to-back operations SHALL issue without stall; the LRU store forwards writes to reads.
REQ-025 In IDLE with no grant: lru_addr=0, lru_used_index=0, lru_enable_write=0.
REQ-026 rsp_port/rsp_way SHALL be registered; they hold their last values while rsp_valid=0.

Reset
REQ-027 rst SHALL force state=IDLE, rsp_valid=0, rsp_port=0, rsp_way=0, captured set/port=0, RR pointer=0, asynchronously.
REQ-028 rst during MISS_UPD SHALL abandon the miss: no write issued, no response produced.

Configuration
REQ-029 Macro CACHE_LRU_SCHED_RR_EN defined: SHALL use round-robin arbitration; on simultaneous valid, the port other than the last-granted wins; pointer updates on each accept.
REQ-030 Macro undefined: SHALL use fixed priority, requester 0 always wins; no pointer register.

Structure
REQ-031 Package cache_lru_pkg SHALL hold SET_W/WAY_W defaults and the FSM state enum.
REQ-032 Arbitration SHALL be one sub-module, cache_lru_req_arb, containing the macro-controlled logic.

Verification
REQ-033 Single hit, port 0, set 0x155, way 2 -> lru_enable_write=1 with lru_addr=0x155 and used_index=2 that cycle; rsp_valid, rsp_port=0, rsp_way=2 next cycle.
REQ-034 Miss, port 1, set 0x7FF, LRU returns 3 -> no write at T; write to 0x7FF with used_index=3 at T+1; req_ready=0 at T+1; rsp_port=1, rsp_way=3 at T+2.
REQ-035 Both ports valid for 4 hits each -> with macro, grants alternate 0,1,0,1...; without macro, port 0 is granted 4 times first.
REQ-036 Hits to set 0x010 on ways 0,1,2,3 back-to-back, then miss on 0x010 -> victim 0.
REQ-037 rst asserted at T+1 of a miss -> lru_enable_write=0 immediately, no rsp_valid, IDLE accepts a new request after rst deasserts.
